alu_seq_param: RTL and testbench



---
 rtl/alu_seq_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered, parametrised ALU with valid/ready handshakes.
// Keeps the legacy 8-bit op codes (ADD/SUB/XOR/SHL1 with op[2]=0).
// It adds AND, multi-cycle logical shifts and a shift-add multiply.
// All ops report carry/zero/negative/overflow flags.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; a, b, op captured on accept
//   a, b                 operands (shift amount in b[SHW-1:0])
//   op                   operation code
//   out_valid/out_ready  result handshake; res and flags held until transfer
//   res                  WIDTH-bit result
//   flag_c/z/n/v         carry-borrow-shiftout-mulovf / zero / negative / overflow
module alu_seq_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SHL1 = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;   // shift operand, or multiplicand for MUL
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product, remaining multiplier}
  logic [SHW-1:0]     cnt_q, cnt_d;     // BUSY steps still to perform
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c, fin_v;
  logic [WIDTH:0]     step;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH+1:0]   alu;
  logic [SHW-1:0]     shamt;

  // One single-bit shift: returns {bit shifted out, shifted word}.
  function automatic logic [WIDTH:0] shift_step(input logic right,
                                                input logic [WIDTH-1:0] w);
    if (right) return {w[0], 1'b0, w[WIDTH-1:1]};
    else       return {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
  endfunction

  // One shift-add multiply step: add the multiplicand into the upper half
  // when the current multiplier LSB is set, then shift the whole accumulator
  // right. After WIDTH steps the accumulator holds the full product.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] hi;
    hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {hi, acc[WIDTH-1:1]};
  endfunction

  // Single-cycle ops: returns {v, c, result}.
  function automatic logic [WIDTH+1:0] alu_single(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c, v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (o)
      OP_ADD: begin
        sum = {1'b0, x} + {1'b0, y};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        sum = {1'b0, x} - {1'b0, y};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_XOR:  r = x ^ y;
      OP_SHL1: begin
        r = {x[WIDTH-2:0], 1'b0};
        c = x[WIDTH-1];
      end
      default: r = x & y;
    endcase
    return {v, c, r};
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    step     = '0;
    acc_step = '0;
    alu      = '0;
    shamt    = b[SHW-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          case (op)
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                fin     = 1'b1;
                fin_res = a;
              end else begin
                // The accept edge already performs the first bit step so
                // an n-bit shift completes in n cycles; n=1 finishes here.
                step = shift_step(op[0], a);
                if (shamt == SHW'(1)) begin
                  fin     = 1'b1;
                  fin_res = step[WIDTH-1:0];
                  fin_c   = step[WIDTH];
                end else begin
                  work_d  = step[WIDTH-1:0];
                  cnt_d   = shamt - SHW'(1);
                  state_d = BUSY;
                end
              end
            end
            OP_MUL: begin
              // First multiply step also runs on the accept edge.
              work_d  = a;
              acc_d   = mul_step({{WIDTH{1'b0}}, b}, a);
              cnt_d   = SHW'(WIDTH - 1);
              state_d = BUSY;
            end
            default: begin
              alu     = alu_single(op, a, b);
              fin     = 1'b1;
              fin_res = alu[WIDTH-1:0];
              fin_c   = alu[WIDTH];
              fin_v   = alu[WIDTH+1];
            end
          endcase
        end
      end

      BUSY: begin
        if (op_q == OP_MUL) begin
          acc_step = mul_step(acc_q, work_q);
          acc_d    = acc_step;
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = acc_step[WIDTH-1:0];
            fin_c   = |acc_step[2*WIDTH-1:WIDTH];
          end
        end else begin
          step   = shift_step(op_q[0], work_q);
          work_d = step[WIDTH-1:0];
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = step[WIDTH-1:0];
            fin_c   = step[WIDTH];
          end
        end
        cnt_d = cnt_q - SHW'(1);
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = DONE;
      res_d   = fin_res;
      c_d     = fin_c;
      v_d     = fin_v;
      z_d     = (fin_res == '0);
      n_d     = fin_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: randomized self-checking bench for alu_seq_param (WIDTH=8).
// Expected results come from an arithmetic reference model of the op set.
module tb_alu_seq_param;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, res;
  logic [2:0]   op;
  logic         flag_c, flag_z, flag_n, flag_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op definitions.
  task automatic model(input int ai, input int bi, input int o,
                       output int r, output int c, output int v, output int lat);
    int mask, sa, sb, s, n, p;
    mask = (1 << W) - 1;
    sa   = (ai >= 2**(W-1)) ? ai - 2**W : ai;
    sb   = (bi >= 2**(W-1)) ? bi - 2**W : bi;
    n    = bi % W;
    c = 0; v = 0; lat = 1; r = 0;
    case (o)
      0: begin r = (ai + bi) & mask; c = (ai + bi > mask); s = sa + sb;
               v = (s > 2**(W-1) - 1 || s < -(2**(W-1))); end
      1: begin r = (ai - bi) & mask; c = (ai < bi); s = sa - sb;
               v = (s > 2**(W-1) - 1 || s < -(2**(W-1))); end
      2: r = ai ^ bi;
      3: begin r = (ai * 2) & mask; c = ai / 2**(W-1); end
      4: begin r = (ai << n) & mask; c = (n == 0) ? 0 : (ai >> (W - n)) & 1;
               lat = (n == 0) ? 1 : n; end
      5: begin r = ai >> n; c = (n == 0) ? 0 : (ai >> (n - 1)) & 1;
               lat = (n == 0) ? 1 : n; end
      6: begin p = ai * bi; r = p & mask; c = (p > mask); lat = W; end
      default: r = ai & bi;
    endcase
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic run_op(input int ai, input int bi, input int o, input int hold);
    int er, ec, ev, el, lat;
    logic [W-1:0] r0;
    logic [3:0]   f0;
    model(ai, bi, o, er, ec, ev, el);
    a = W'(ai); b = W'(bi); op = 3'(o); in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs: captured operands must not follow them.
    a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_valid = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, el);
    check("res", res, er);
    check("flag_c", flag_c, ec);
    check("flag_z", flag_z, (er == 0));
    check("flag_n", flag_n, er / 2**(W-1));
    check("flag_v", flag_v, ev);
    check("in_ready_done", in_ready, 0);
    r0 = res; f0 = {flag_c, flag_z, flag_n, flag_v};
    in_valid = 1'b1;
    repeat (hold) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_res", res, r0);
      check("hold_flags", {flag_c, flag_z, flag_n, flag_v}, f0);
      check("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("xfer_valid", out_valid, 0);
    check("xfer_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'hF0, 8'h20, 0, 0);
    run_op(8'h7F, 8'h01, 0, 0);
    run_op(8'h05, 8'h07, 1, 0);
    run_op(8'h80, 8'h01, 1, 0);
    run_op(8'hAA, 8'hAA, 2, 0);
    run_op(8'h81, 8'h03, 4, 0);
    run_op(8'h81, 8'h00, 5, 0);
    run_op(8'h81, 8'h07, 5, 1);
    run_op(8'h81, 8'h01, 4, 0);
    run_op(8'h81, 8'h00, 3, 0);
    run_op(8'h10, 8'h11, 6, 5);
    run_op(8'h0F, 8'h0F, 6, 0);

    // Reset four cycles into a multiply.
    a = 8'h33; b = 8'h44; op = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
    check("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 1, 0, 0);

    for (int i = 0; i < 150; i++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
